// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - key_state_t : debounce FSM states (IDLE / DEBOUNCE / PRESSED / RELEASE)
//   - KEY_MAP     : 16-entry hex code table indexed by {row[1:0], col[1:0]}
//   - COL_SELECT  : one-cold column drive patterns indexed by column number
//   - shift_digit : pushes a new hex digit into the low nibble of a 16-bit value
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_t;

    // Index = {row, col}. Listed from index 15 (r3c3) down to index 0 (r0c0).
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,   // r3: c3..c0
        4'hC, 4'h9, 4'h8, 4'h7,   // r2
        4'hB, 4'h6, 4'h5, 4'h4,   // r1
        4'hA, 4'h3, 4'h2, 4'h1    // r0
    };

    // Column c pulls exactly one line low; col0 drives the MSB low.
    localparam logic [3:0][3:0] COL_SELECT = {
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    function automatic logic [15:0] shift_digit(input logic [15:0] v, input logic [3:0] d);
        return {v[11:0], d};
    endfunction

endpackage

// File: rtl/keypad_scanner_clkdiv.sv
// -----------------------------------------------------------------------------
// keypad_scanner_clkdiv
// Free-running divider producing a one-clock tick every DIV clocks. The tick is
// high on the last clock of each DIV-clock period.
// Ports:
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset
//   tick  out 1  one-cycle pulse every DIV clocks
// -----------------------------------------------------------------------------
module keypad_scanner_clkdiv #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_reg;

    assign tick = (cnt_reg == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, synchronises the
// rows, picks the first pressed key of each 4-column frame, debounces it over
// DEBOUNCE_FRAMES frames and shifts every accepted hex digit into 'value'.
// Optional build macro: KEYPAD_CLEAR_EN -- an accepted E key clears 'value'
// instead of shifting in (key_valid / key_code behave as for any key).
// Ports:
//   clk        in  1   system clock
//   rst_n      in  1   asynchronous active-low reset
//   keypad_row in  4   raw rows, active low, asynchronous to clk
//   keypad_col out 4   one-cold column drive (col0 = 4'b0111)
//   value      out 16  entered digits, newest in [3:0]
//   key_code   out 4   code of the last accepted key
//   key_valid  out 1   one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLOCK_SPEED     = 0,
    parameter int SCAN_RATE       = 1000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  keypad_row,
    output logic [3:0]  keypad_col,
    output logic [15:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    // Four clocks minimum: the 2-flop synchroniser must settle after a column
    // change before the rows are sampled on the last clock of the period.
    localparam int COL_DIV_RAW = (SCAN_RATE > 0) ? (CLOCK_SPEED / SCAN_RATE / 4) : 0;
    localparam int COL_DIV     = (COL_DIV_RAW < 4) ? 4 : COL_DIV_RAW;
    localparam int CNT_W       = $clog2(DEBOUNCE_FRAMES + 1) + 1;
    localparam logic [CNT_W-1:0] DF_CNT = CNT_W'(DEBOUNCE_FRAMES);

    logic        col_tick;
    logic [1:0]  col_idx_reg;
    logic [3:0]  row_meta_reg;
    logic [3:0]  row_sync_reg;
    logic        frame_hit_reg;
    logic [3:0]  frame_code_reg;

    logic        col_hit;
    logic [1:0]  row_sel;
    logic [3:0]  col_code;
    logic        cand_hit;
    logic [3:0]  cand_code;
    logic        frame_end;

    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       code_reg, code_next;
    logic [15:0]      value_reg, value_next;
    logic [3:0]       key_code_reg, key_code_next;
    logic             key_valid_reg, key_valid_next;
    logic             accept;

    keypad_scanner_clkdiv #(
        .DIV (COL_DIV)
    ) u_col_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (col_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= keypad_row;
            row_sync_reg <= row_meta_reg;
        end
    end

    // Lowest asserted row of the current column wins.
    always_comb begin
        row_sel = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync_reg[r]) begin
                row_sel = 2'(r);
            end
        end
    end

    assign col_hit  = ~&row_sync_reg;
    assign col_code = KEY_MAP[{row_sel, col_idx_reg}];

    // The col3 sample is folded in combinationally so the frame result is
    // available on the very tick that wraps the scan back to col0.
    assign frame_end = col_tick && (col_idx_reg == 2'd3);
    assign cand_hit  = frame_hit_reg | col_hit;
    assign cand_code = frame_hit_reg ? frame_code_reg : col_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_idx_reg    <= 2'd0;
            frame_hit_reg  <= 1'b0;
            frame_code_reg <= 4'h0;
        end else if (col_tick) begin
            col_idx_reg <= col_idx_reg + 2'd1;
            if (col_idx_reg == 2'd3) begin
                frame_hit_reg  <= 1'b0;
                frame_code_reg <= 4'h0;
            end else if (!frame_hit_reg && col_hit) begin
                frame_hit_reg  <= 1'b1;
                frame_code_reg <= col_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            code_reg      <= 4'h0;
            value_reg     <= 16'h0000;
            key_code_reg  <= 4'h0;
            key_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            code_reg      <= code_next;
            value_reg     <= value_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        code_next      = code_reg;
        value_next     = value_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        accept         = 1'b0;

        if (frame_end) begin
            case (state_reg)
                ST_IDLE: begin
                    if (cand_hit) begin
                        code_next = cand_code;
                        cnt_next  = CNT_W'(1);
                        if (CNT_W'(1) >= DF_CNT) begin
                            accept     = 1'b1;
                            state_next = ST_PRESSED;
                        end else begin
                            state_next = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (cand_hit && (cand_code == code_reg)) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_next >= DF_CNT) begin
                            accept     = 1'b1;
                            state_next = ST_PRESSED;
                        end
                    end else begin
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    // Any hit, even a different key, keeps the press latched.
                    if (!cand_hit) begin
                        cnt_next   = CNT_W'(1);
                        state_next = (CNT_W'(1) >= DF_CNT) ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (cand_hit) begin
                        state_next = ST_PRESSED;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_next >= DF_CNT) begin
                            cnt_next   = '0;
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            endcase
        end

        if (accept) begin
            key_valid_next = 1'b1;
            key_code_next  = cand_code;
`ifdef KEYPAD_CLEAR_EN
            if (cand_code == 4'hE) begin
                value_next = 16'h0000;
            end else begin
                value_next = shift_digit(value_reg, cand_code);
            end
`else
            value_next = shift_digit(value_reg, cand_code);
`endif
        end
    end

    assign keypad_col = COL_SELECT[col_idx_reg];
    assign value      = value_reg;
    assign key_code   = key_code_reg;
    assign key_valid  = key_valid_reg;

endmodule
